// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry elastic IF->ID buffer with redirect flush and a saturating stall-cycle counter.
// Main entry drives ID straight from flops; the skid entry absorbs one fetch while ID is stalled.
module if_id_buffer #(
    parameter int PC_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013,
    parameter int CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [PC_WIDTH-1:0]   if_pc,
    input  logic [INST_WIDTH-1:0] if_inst,
    input  logic                  flush,
    input  logic                  id_stall,
    output logic                  id_valid,
    output logic [PC_WIDTH-1:0]   id_pc,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    state_t state, state_n;
    logic [PC_WIDTH-1:0] main_pc, main_pc_n, skid_pc;
    logic [INST_WIDTH-1:0] main_inst, main_inst_n, skid_inst;
    logic skid_we, accept, consume;
    assign id_valid = state != EMPTY;
    assign id_pc = main_pc;
    assign id_inst = main_inst;
    assign accept = if_valid & if_ready;
    assign consume = id_valid & ~id_stall;
    always_comb begin
        state_n = state;
        main_pc_n = main_pc;
        main_inst_n = main_inst;
        skid_we = 1'b0;
        if (flush) begin
            state_n = EMPTY;
            main_pc_n = '0;
            main_inst_n = NOP_INST;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_n = ONE;
                    main_pc_n = if_pc;
                    main_inst_n = if_inst;
                end
                ONE: if (accept && consume) begin
                    main_pc_n = if_pc;
                    main_inst_n = if_inst;
                end else if (accept) begin
                    state_n = TWO;
                    skid_we = 1'b1;
                end else if (consume) begin
                    state_n = EMPTY;
                    main_pc_n = '0;
                    main_inst_n = NOP_INST;
                end
                TWO: if (consume) begin
                    state_n = ONE;
                    main_pc_n = skid_pc;
                    main_inst_n = skid_inst;
                end
                default: state_n = EMPTY;
            endcase
        end
    end
    // if_ready comes from the next count so id_stall never reaches it combinationally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            if_ready <= 1'b1;
            main_pc <= '0;
            main_inst <= NOP_INST;
            skid_pc <= '0;
            skid_inst <= NOP_INST;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            if_ready <= state_n != TWO;
            main_pc <= main_pc_n;
            main_inst <= main_inst_n;
            if (skid_we) begin
                skid_pc <= if_pc;
                skid_inst <= if_inst;
            end
            if (id_valid && id_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: queue-model scoreboard plus a directed vector table for the IF/ID buffer.
module tb_if_id_buffer;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic if_valid = 1'b0;
    logic flush = 1'b0;
    logic id_stall = 1'b0;
    logic [63:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic if_ready, id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic [3:0] stall_cnt;

    if_id_buffer #(.PC_WIDTH(64), .INST_WIDTH(32), .NOP_INST(32'h13), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_inst(if_inst), .flush(flush), .id_stall(id_stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic v;
        logic [63:0] pc;
        logic fl;
        logic st;
        logic ev;
        logic [63:0] epc;
        logic er;
        logic [3:0] ecnt;
    } vec_t;

    ent_t mq[$];
    logic m_ready = 1'b1;
    logic [3:0] m_cnt = '0;
    int pass_cnt = 0;
    int total = 0;
    vec_t tbl[12];

    function automatic logic [31:0] mk_inst(input logic [63:0] pc);
        return pc[31:0] ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic post_chk();
        logic ne;
        ne = mq.size() != 0;
        chk("id_valid", 64'(id_valid), 64'(ne));
        chk("id_pc", id_pc, ne ? mq[0].pc : 64'h0);
        chk("id_inst", 64'(id_inst), 64'(ne ? mq[0].inst : NOP));
        chk("if_ready", 64'(if_ready), 64'(m_ready));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    // drive one cycle, advance the queue model, check the registered outputs afterwards
    task automatic cyc(input logic v, input logic [63:0] pc, input logic fl, input logic st);
        ent_t e;
        if_valid = v;
        if_pc = pc;
        if_inst = mk_inst(pc);
        flush = fl;
        id_stall = st;
        #1;
        if (mq.size() != 0 && st && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        if (mq.size() != 0 && !st) begin
            chk("consume_pc", id_pc, mq[0].pc);
            chk("consume_inst", 64'(id_inst), 64'(mq[0].inst));
        end
        if (fl) mq.delete();
        else begin
            if (mq.size() != 0 && !st) void'(mq.pop_front());
            if (v && m_ready) begin
                e.pc = pc;
                e.inst = mk_inst(pc);
                mq.push_back(e);
            end
        end
        m_ready = mq.size() != 2;
        @(posedge clk);
        #1;
        post_chk();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_valid = 1'b1;
        flush = 1'b1;
        id_stall = 1'b1;
        if_pc = 64'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        m_ready = 1'b1;
        m_cnt = '0;
        post_chk();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 64'h8000_0000, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 1'b1, 4'd0};
        tbl[1]  = '{1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b1, 64'h8000_0004, 1'b1, 4'd0};
        tbl[2]  = '{1'b1, 64'h8000_0008, 1'b0, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 4'd1};
        tbl[3]  = '{1'b1, 64'h8000_000C, 1'b0, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 4'd2};
        tbl[4]  = '{1'b1, 64'h8000_000C, 1'b0, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 4'd3};
        tbl[5]  = '{1'b1, 64'h8000_000C, 1'b0, 1'b0, 1'b1, 64'h8000_0008, 1'b1, 4'd3};
        tbl[6]  = '{1'b1, 64'h8000_000C, 1'b0, 1'b0, 1'b1, 64'h8000_000C, 1'b1, 4'd3};
        tbl[7]  = '{1'b0, 64'h0,         1'b0, 1'b0, 1'b0, 64'h0,         1'b1, 4'd3};
        tbl[8]  = '{1'b1, 64'h8000_0200, 1'b0, 1'b1, 1'b1, 64'h8000_0200, 1'b1, 4'd3};
        tbl[9]  = '{1'b1, 64'h8000_0204, 1'b0, 1'b1, 1'b1, 64'h8000_0200, 1'b0, 4'd4};
        tbl[10] = '{1'b1, 64'h8000_0208, 1'b1, 1'b1, 1'b0, 64'h0,         1'b1, 4'd5};
        tbl[11] = '{1'b1, 64'h8000_0100, 1'b0, 1'b0, 1'b1, 64'h8000_0100, 1'b1, 4'd5};
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].v, tbl[i].pc, tbl[i].fl, tbl[i].st);
            chk($sformatf("vec%0d_valid", i), 64'(id_valid), 64'(tbl[i].ev));
            chk($sformatf("vec%0d_pc", i), id_pc, tbl[i].epc);
            chk($sformatf("vec%0d_inst", i), 64'(id_inst), 64'(tbl[i].ev ? mk_inst(tbl[i].epc) : NOP));
            chk($sformatf("vec%0d_ready", i), 64'(if_ready), 64'(tbl[i].er));
            chk($sformatf("vec%0d_cnt", i), 64'(stall_cnt), 64'(tbl[i].ecnt));
        end
        cyc(1'b0, 64'h0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0);
            chk("stream_pc", id_pc, 64'h8000_0000 + 64'(4 * i));
            chk("stream_ready", 64'(if_ready), 64'h1);
        end
        cyc(1'b0, 64'h0, 1'b0, 1'b0);
        do_reset();
        cyc(1'b1, 64'h8000_0400, 1'b0, 1'b0);
        for (int i = 0; i < 21; i++) cyc(1'b0, 64'h0, 1'b0, 1'b1);
        chk("sat_cnt", 64'(stall_cnt), 64'hF);
        cyc(1'b0, 64'h0, 1'b0, 1'b1);
        chk("sat_hold", 64'(stall_cnt), 64'hF);
        chk("sat_main_pc", id_pc, 64'h8000_0400);
        cyc(1'b0, 64'h0, 1'b1, 1'b1);
        chk("flush_keeps_cnt", 64'(stall_cnt), 64'hF);
        do_reset();
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 3) != 0, 64'h9000_0000 + 64'(4 * i),
                $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
